// File: rtl/cas_pkg.sv
// Shared types and defaults for the cassette FSK playback serialiser.
package cas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cas_state_t;

  // 50 MHz / 4800 and 50 MHz / 2400: half-periods of the 2400 Hz and 1200 Hz tones
  localparam int CAS_HALF1_DEFAULT = 10417;
  localparam int CAS_HALF0_DEFAULT = 20833;
  localparam int CAS_CNT_W         = 16;

  // Last count of a half-period for the bit being played
  function automatic logic [CAS_CNT_W-1:0] cas_half_last(input logic sel_one,
                                                         input int   half1,
                                                         input int   half0);
    return sel_one ? CAS_CNT_W'(half1 - 1) : CAS_CNT_W'(half0 - 1);
  endfunction

endpackage

// File: rtl/cas_halfcycle_timer.sv
// Half-period timer: counts enabled cycles and flags the last cycle of a half.
import cas_pkg::*;

module cas_halfcycle_timer #(
  parameter int HALF1_CYC = CAS_HALF1_DEFAULT,
  parameter int HALF0_CYC = CAS_HALF0_DEFAULT,
  parameter int CNT_W     = CAS_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  input  logic sel_one,
  output logic done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_last;

  assign h_last = sel_one ? CNT_W'(HALF1_CYC - 1) : CNT_W'(HALF0_CYC - 1);

  // done only fires on a cycle that actually advances, so a frozen motor never ends a half
  assign done = run & ~clear & (cnt == h_last);

  // Count enabled cycles, wrap to 0 on the last one; clear wins over run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= (cnt == h_last) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/cas_fsk_serializer.sv
// Cassette playback output stage: bytes in, LSB-first CoCo FSK square wave out.
import cas_pkg::*;

module cas_fsk_serializer #(
  parameter int HALF1_CYC = CAS_HALF1_DEFAULT,
  parameter int HALF0_CYC = CAS_HALF0_DEFAULT,
  parameter int CNT_W     = CAS_CNT_W
) (
  input  logic       CLK50MHZ,
  input  logic       COCO_RESET_N,
  input  logic       en,
  input  logic       rewind,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       casdout,
  output logic       busy,
  output logic       underrun
);

  cas_state_t state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       half_done;
  logic       tmr_run;
  logic       tmr_clear;

  // Timer advances only while a byte is playing and the motor is on
  assign tmr_run   = en & (state != IDLE);
  assign tmr_clear = rewind | (state == IDLE);

  cas_halfcycle_timer #(
    .HALF1_CYC (HALF1_CYC),
    .HALF0_CYC (HALF0_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk     (CLK50MHZ),
    .reset_n (COCO_RESET_N),
    .run     (tmr_run),
    .clear   (tmr_clear),
    .sel_one (shreg[0]),
    .done    (half_done)
  );

  // Ready in IDLE, or on the very last cycle of a byte so the next one follows gaplessly
  always_comb begin
    byte_ready = 1'b0;
    if (COCO_RESET_N && en && !rewind) begin
      case (state)
        IDLE:    byte_ready = 1'b1;
        LOW:     byte_ready = (bit_idx == 3'd7) & half_done;
        default: byte_ready = 1'b0;
      endcase
    end
  end

  // Playback FSM with registered waveform, busy and underrun outputs
  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      casdout  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (rewind) begin
        state   <= IDLE;
        bit_idx <= '0;
        casdout <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (byte_valid && byte_ready) begin
              shreg   <= byte_data;
              bit_idx <= '0;
              state   <= HIGH;
              casdout <= 1'b1;
              busy    <= 1'b1;
            end
          end
          HIGH: begin
            if (half_done) begin
              state   <= LOW;
              casdout <= 1'b0;
            end
          end
          LOW: begin
            if (half_done) begin
              if (bit_idx != 3'd7) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
                state   <= HIGH;
                casdout <= 1'b1;
              end else if (byte_valid) begin
                // byte_ready is necessarily high here, so this is the handshake
                shreg   <= byte_data;
                bit_idx <= '0;
                state   <= HIGH;
                casdout <= 1'b1;
              end else begin
                underrun <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
              end
            end
          end
          default: begin
            state   <= IDLE;
            casdout <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cas_fsk_serializer.sv
// Directed bench for cas_fsk_serializer with shortened half-periods.
module tb_cas_fsk_serializer;

  localparam int H1  = 3;
  localparam int H0  = 5;
  localparam int LOG = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, rewind, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, casdout, busy, underrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit co_log [LOG];
  bit ur_log [LOG];
  bit by_log [LOG];
  bit rd_log [LOG];
  bit hs_log [LOG];

  cas_fsk_serializer #(.HALF1_CYC(H1), .HALF0_CYC(H0), .CNT_W(16)) dut (
    .CLK50MHZ     (clk),
    .COCO_RESET_N (rst_n),
    .en           (en),
    .rewind       (rewind),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .casdout      (casdout),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Per-cycle trace: entry i is the state after posedge i; hs means acceptance at the next posedge
  always @(negedge clk) begin
    if (cyc < LOG) begin
      co_log[cyc] = casdout;
      ur_log[cyc] = underrun;
      by_log[cyc] = busy;
      rd_log[cyc] = byte_ready;
      hs_log[cyc] = byte_ready & byte_valid;
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int run_len(input int s, input bit lvl);
    int n = 0;
    while (s + n < LOG && co_log[s+n] == lvl && n < 200) n++;
    return n;
  endfunction

  function automatic int find_hs(input int from);
    for (int i = from; i < LOG && i < cyc; i++) if (hs_log[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones_ur(input int s, input int e);
    int n = 0;
    for (int i = s; i <= e && i < LOG; i++) n += ur_log[i];
    return n;
  endfunction

  function automatic int count_ones_rd(input int s, input int e);
    int n = 0;
    for (int i = s; i <= e && i < LOG; i++) n += rd_log[i];
    return n;
  endfunction

  // Present a byte and wait (bounded) for the handshake; returns at posedge+1 after acceptance
  task automatic send(input logic [7:0] d, input bit hold);
    bit ok = 0;
    byte_data  = d;
    byte_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (byte_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!hold) byte_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Check each half of a byte accepted at trace entry a; p ends at the entry after the byte
  task automatic walk(input int a, input logic [7:0] b, input bit gapless, output int p);
    int h;
    p = a + 1;
    for (int i = 0; i < 8; i++) begin
      h = b[i] ? H1 : H0;
      chk($sformatf("hi_b%0d", i), run_len(p, 1'b1), h);
      p += h;
      if (i < 7 || gapless) chk($sformatf("lo_b%0d", i), run_len(p, 1'b0), h);
      p += h;
    end
  endtask

  initial begin
    int mark, a, a2, p;
    rst_n = 1'b0; en = 1'b1; rewind = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // reset values; byte_ready is held low by reset even with the motor on
    #12;
    chk("rst_casdout", casdout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", byte_ready, 0);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    chk("idle_ready", byte_ready, 1);
    tick(2);

    // single 0x01, nothing follows: 3/3 then 7x 5/5, underrun 2*3+14*5+1 entries later
    mark = cyc;
    send(8'h01, 1'b0);
    wait_idle();
    a = find_hs(mark);
    walk(a, 8'h01, 1'b0, p);
    chk("b01_len", p - a - 1, 76);
    chk("b01_ur_at_end", ur_log[p], 1);
    chk("b01_busy_fall", by_log[p], 0);
    chk("b01_busy_last", by_log[p-1], 1);
    chk("b01_ur_count", count_ones_ur(a, p + 3), 1);
    tick(3);

    // 0xFF then 0x00 with valid held: one ready cycle at byte end, no gap
    mark = cyc;
    send(8'hFF, 1'b1);
    byte_data = 8'h00;
    send(8'h00, 1'b0);
    wait_idle();
    a  = find_hs(mark);
    a2 = find_hs(a + 1);
    chk("strm_gapless", a2 - a, 48);
    chk("strm_ready_once", count_ones_rd(a + 1, a2), 1);
    chk("strm_no_ur_mid", count_ones_ur(a, a2 + 1), 0);
    walk(a, 8'hFF, 1'b1, p);
    chk("strm_b1_end", p, a2 + 1);
    walk(a2, 8'h00, 1'b0, p);
    chk("strm_b2_len", p - a2 - 1, 80);
    chk("strm_ur", ur_log[p], 1);
    tick(3);

    // 0x00, motor off 20 cycles during bit-3 HIGH: HIGH stretches, byte stretches by 20
    mark = cyc;
    send(8'h00, 1'b0);
    tick(31);
    en = 1'b0;
    tick(20);
    en = 1'b1;
    wait_idle();
    a = find_hs(mark);
    chk("en_pre_low", co_log[a+30], 0);
    chk("en_hi_b3", run_len(a + 31, 1'b1), H0 + 20);
    chk("en_hi_b0", run_len(a + 1, 1'b1), H0);
    chk("en_ur_at", ur_log[a+101], 1);
    chk("en_ur_count", count_ones_ur(a, a + 104), 1);
    tick(3);

    // rewind during bit 5 of 0xAA: idle next cycle, no underrun; next byte plays from bit 0
    mark = cyc;
    send(8'hAA, 1'b0);
    tick(43);
    rewind = 1'b1;
    tick(1);
    rewind = 1'b0;
    tick(2);
    a = find_hs(mark);
    chk("rw_in_b5", co_log[a+44], 1);
    chk("rw_ready_low", rd_log[a+44], 0);
    chk("rw_casdout", co_log[a+45], 0);
    chk("rw_busy", by_log[a+45], 0);
    chk("rw_ready_back", rd_log[a+45], 1);
    chk("rw_no_ur", count_ones_ur(a, a + 46), 0);
    mark = cyc;
    send(8'h01, 1'b0);
    wait_idle();
    a = find_hs(mark);
    walk(a, 8'h01, 1'b0, p);
    chk("rw_next_ur", ur_log[p], 1);
    tick(3);

    // motor off at byte end, valid low: nothing happens until the motor returns
    mark = cyc;
    send(8'h01, 1'b0);
    tick(73);
    en = 1'b0;
    tick(10);
    en = 1'b1;
    wait_idle();
    a = find_hs(mark);
    chk("eoff_no_ur", count_ones_ur(a, a + 86), 0);
    chk("eoff_busy_held", by_log[a+84], 1);
    chk("eoff_ready_low", count_ones_rd(a + 75, a + 84), 0);
    chk("eoff_ur_at", ur_log[a+87], 1);
    tick(3);

    // async reset during a LOW half
    send(8'h01, 1'b0);
    tick(4);
    chk("mid_low", casdout, 0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("arst_casdout", casdout, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", byte_ready, 0);
    #2; rst_n = 1'b1; #1;
    chk("arst_rel_ready", byte_ready, 1);
    en = 1'b0; #1;
    chk("arst_rel_ready_en0", byte_ready, 0);
    en = 1'b1;
    tick(3);
    chk("arst_stays_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cas_fsk_serializer.md
Name: cas_fsk_serializer

Overview:
- Output stage of the cassette playback path.
- Takes tape image bytes from the tape-buffer fetcher over a valid/ready handshake and serialises them LSB-first into the CoCo FSK waveform on casdout: bit 1 is one 2400 Hz cycle, bit 0 is one 1200 Hz cycle.
- The cassette relay (motor) gates playback.
- casdout drives the PIA cassette input and the optional tape-monitor audio mix.

Parameters:
- HALF1_CYC, 10417: clock cycles per half-period of a '1' bit (50 MHz / 4800).
- HALF0_CYC, 20833: clock cycles per half-period of a '0' bit (50 MHz / 2400).
- CNT_W, 16: width of the half-period counter; must hold HALF0_CYC-1.

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz.
- COCO_RESET_N  in  1  asynchronous active-low reset.
- en  in  1  cassette relay / motor on.
- rewind  in  1  synchronous abort; clears serialiser state.
- byte_data  in  8  next tape byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  serialiser accepts byte_data this cycle.
- casdout  out  1  FSK square-wave output.
- busy  out  1  a byte is being serialised.
- underrun  out  1  one-cycle pulse: stream starved at a byte boundary.

Behaviour:
- Clock and reset:
  - One clock, CLK50MHZ; reset COCO_RESET_N is asynchronous and active-low.
  - Reset values: state=IDLE, casdout=0, busy=0, underrun=0, shift register=0, bit_idx=0, cnt=0.
  - byte_ready is combinational from state and is therefore 0 during reset.
- States: IDLE, HIGH, LOW (enum in package).
- IDLE:
  - casdout=0, busy=0; byte_ready = en & ~rewind.
  - On byte_valid & byte_ready: latch byte_data into shreg, bit_idx=0, cnt=0, go to HIGH.
- HIGH:
  - casdout=1.
  - Half length H = shreg[0] ? HALF1_CYC : HALF0_CYC.
  - cnt increments each enabled cycle; at cnt==H-1, cnt=0 and go to LOW.
- LOW:
  - casdout=0, same H.
  - At cnt==H-1 (bit end):
    - If bit_idx<7: shreg shifts right, bit_idx+1, go to HIGH.
    - If bit_idx==7 (byte end):
      - byte_valid=1: load the new byte and go to HIGH next cycle, with no gap cycle.
      - byte_valid=0: pulse underrun for 1 cycle, go to IDLE.
- byte_ready in LOW = en & ~rewind & bit_idx==7 & cnt==H-1. This allows gapless back-to-back bytes.
- Bit timing:
  - Bit duration = 2·H cycles.
  - A '1' bit is 20834 cycles; a '0' bit is 41666 cycles at the default parameters.
- busy = 1 in HIGH and LOW.
- en=0 (motor off):
  - In HIGH or LOW, freeze cnt, state and casdout; resume exactly where stopped when en returns.
  - byte_ready=0 while en=0.
  - The byte-end transition does not fire while en=0, so no underrun is reported while the motor is off.
- rewind=1:
  - Next cycle: state=IDLE, casdout=0, cnt=0, bit_idx=0; the partial byte is discarded.
  - No underrun pulse; byte_ready=0 during the rewind cycle.
  - rewind has priority over en, the handshake and the counter.
- Reset mid-byte: asynchronous return to the reset values; the byte in flight is lost.
- Counter: unsigned, compares against H-1, never wraps past H-1.

Decomposition:
- Package cas_pkg holds:
  - typedef enum {IDLE, HIGH, LOW} cas_state_t;
  - constants CAS_HALF1_DEFAULT=10417 and CAS_HALF0_DEFAULT=20833;
  - CAS_CNT_W=16.
- One sub-module, cas_halfcycle_timer:
  - Inputs: clk, reset_n, run, clear, sel_one.
  - Outputs: done pulse when cnt==H-1.
  - Owns cnt and the H selection.
- The FSM, shift register, handshake and casdout stay in the top.

Test Plan:
- Single byte 0x01, en=1, no follow-on byte:
  - casdout high 10417, low 10417, then seven cycles of high 20833 / low 20833.
  - underrun pulses at cycle 312496 after acceptance; busy falls the same cycle.
- Stream 0xFF then 0x00, valid held high:
  - byte_ready is asserted for exactly one cycle at the end of byte 1.
  - The second byte's first HIGH starts the next cycle with no idle gap.
  - Totals: 8×20834, then 8×41666 cycles.
- 0x00 in flight, drop en for 1000 cycles mid-HIGH of bit 3:
  - casdout stays 1 and the bit-3 HIGH half still totals 20833 enabled cycles.
  - Total byte time = 333328 + 1000.
- rewind pulse during bit 5 of 0xAA:
  - Next cycle state=IDLE, casdout=0, busy=0, no underrun.
  - Next accepted byte starts from its bit 0.
- en=0 at byte end with valid=0: no underrun and no state change until en=1.
- COCO_RESET_N low mid-LOW: casdout=0, busy=0 and byte_ready=0 immediately; after release, byte_ready=en.
